// File: rtl/score_tracker.sv
// Game score tracker: BCD round counter with a best-score register and a new-record blink.
// Best tracking, new_record and blink are built only when SCORE_TRACKER_BEST_EN is defined.
module score_tracker #(
  parameter int unsigned BLINK_TICKS = 25,
  parameter int unsigned MAX_SCORE   = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_100hz,
  input  logic       game_start,
  input  logic       round_won,
  input  logic       game_over,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [3:0] best_tens,
  output logic [3:0] best_ones,
  output logic       new_record,
  output logic       disp_blank
);

  typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

  localparam logic [3:0] MaxTens = 4'(MAX_SCORE / 10);
  localparam logic [3:0] MaxOnes = 4'(MAX_SCORE % 10);

  state_e     state_q;
  logic [3:0] score_tens_q, score_ones_q;
  logic       at_max;

  assign at_max = (score_tens_q == MaxTens) && (score_ones_q == MaxOnes);

  // game_start outranks game_over, which outranks round_won.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      score_tens_q <= 4'd0;
      score_ones_q <= 4'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (game_start) begin
            state_q      <= StPlay;
            score_tens_q <= 4'd0;
            score_ones_q <= 4'd0;
          end
        end
        StPlay: begin
          if (game_start) begin
            score_tens_q <= 4'd0;
            score_ones_q <= 4'd0;
          end else if (game_over) begin
            state_q <= StOver;
          end else if (round_won && !at_max) begin
            if (score_ones_q == 4'd9) begin
              score_ones_q <= 4'd0;
              score_tens_q <= score_tens_q + 4'd1;
            end else begin
              score_ones_q <= score_ones_q + 4'd1;
            end
          end
        end
        StOver: begin
          if (game_start) begin
            state_q      <= StPlay;
            score_tens_q <= 4'd0;
            score_ones_q <= 4'd0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign score_tens = score_tens_q;
  assign score_ones = score_ones_q;

`ifdef SCORE_TRACKER_BEST_EN
  localparam int unsigned CntW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CntW-1:0] TickLast = CntW'(BLINK_TICKS - 1);

  logic [7:0]      best_q;
  logic            new_record_q, disp_blank_q;
  logic [CntW-1:0] tick_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q       <= 8'd0;
      new_record_q <= 1'b0;
      disp_blank_q <= 1'b0;
      tick_cnt_q   <= '0;
    end else if (game_start) begin
      new_record_q <= 1'b0;
      disp_blank_q <= 1'b0;
      tick_cnt_q   <= '0;
    end else if (state_q == StPlay && game_over) begin
      // Packed BCD digits compare correctly as an unsigned byte.
      if ({score_tens_q, score_ones_q} > best_q) begin
        best_q       <= {score_tens_q, score_ones_q};
        new_record_q <= 1'b1;
      end
    end else if (state_q == StOver && new_record_q && tick_100hz) begin
      if (tick_cnt_q == TickLast) begin
        tick_cnt_q   <= '0;
        disp_blank_q <= ~disp_blank_q;
      end else begin
        tick_cnt_q <= tick_cnt_q + CntW'(1);
      end
    end
  end

  assign best_tens  = best_q[7:4];
  assign best_ones  = best_q[3:0];
  assign new_record = new_record_q;
  assign disp_blank = disp_blank_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{BLINK_TICKS, tick_100hz};

  assign best_tens  = 4'd0;
  assign best_ones  = 4'd0;
  assign new_record = 1'b0;
  assign disp_blank = 1'b0;
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: a decimal reference model pushes expected outputs into a
// scoreboard queue as each stimulus cycle is driven; entries are popped after the clock edge.
module tb_score_tracker;

  localparam int unsigned Blink = 25;
  localparam int unsigned MaxSc = 99;
`ifdef SCORE_TRACKER_BEST_EN
  localparam bit BestEn = 1'b1;
`else
  localparam bit BestEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_100hz = 1'b0, game_start = 1'b0, round_won = 1'b0, game_over = 1'b0;
  logic [3:0] score_tens, score_ones, best_tens, best_ones;
  logic       new_record, disp_blank;

  score_tracker #(.BLINK_TICKS(Blink), .MAX_SCORE(MaxSc)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_100hz (tick_100hz),
    .game_start (game_start),
    .round_won  (round_won),
    .game_over  (game_over),
    .score_tens (score_tens),
    .score_ones (score_ones),
    .best_tens  (best_tens),
    .best_ones  (best_ones),
    .new_record (new_record),
    .disp_blank (disp_blank)
  );

  always #10 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] st, so, bt, bo;
    logic       nr, bl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model in plain decimal integers.
  int m_state = 0;  // 0 idle, 1 play, 2 over
  int m_score = 0, m_best = 0, m_cnt = 0;
  bit m_nr = 0, m_blank = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_best = 0; m_cnt = 0; m_nr = 0; m_blank = 0;
  endtask

  task automatic model_step(input bit gs, input bit rw, input bit go, input bit tk);
    if (gs) begin
      m_state = 1; m_score = 0; m_nr = 0; m_blank = 0; m_cnt = 0;
    end else if (m_state == 1) begin
      if (go) begin
        m_state = 2;
        if (BestEn && m_score > m_best) begin
          m_best = m_score;
          m_nr   = 1;
        end
      end else if (rw && m_score < int'(MaxSc)) begin
        m_score++;
      end
    end else if (m_state == 2 && m_nr && tk) begin
      m_cnt++;
      if (m_cnt == int'(Blink)) begin
        m_cnt   = 0;
        m_blank = !m_blank;
      end
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 8'd0, 8'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".score_tens"}, score_tens, e.st);
      chk({e.tag, ".score_ones"}, score_ones, e.so);
      chk({e.tag, ".best_tens"},  best_tens,  e.bt);
      chk({e.tag, ".best_ones"},  best_ones,  e.bo);
      chk({e.tag, ".new_record"}, new_record, e.nr);
      chk({e.tag, ".disp_blank"}, disp_blank, e.bl);
    end
  endtask

  task automatic step(input bit gs, input bit rw, input bit go, input bit tk, input string tag);
    exp_t e;
    @(negedge clk);
    game_start = gs; round_won = rw; game_over = go; tick_100hz = tk;
    model_step(gs, rw, go, tk);
    e.tag = tag;
    e.st  = 4'(m_score / 10);
    e.so  = 4'(m_score % 10);
    e.bt  = 4'(m_best / 10);
    e.bo  = 4'(m_best % 10);
    e.nr  = m_nr;
    e.bl  = m_blank;
    sb.push_back(e);
    @(posedge clk);
    #1;
    game_start = 0; round_won = 0; game_over = 0; tick_100hz = 0;
    check_outputs();
  endtask

  // Assert reset between clock edges and check outputs clear before any edge arrives.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".score_tens"}, score_tens, 8'd0);
    chk({tag, ".score_ones"}, score_ones, 8'd0);
    chk({tag, ".best_tens"},  best_tens,  8'd0);
    chk({tag, ".best_ones"},  best_ones,  8'd0);
    chk({tag, ".new_record"}, new_record, 8'd0);
    chk({tag, ".disp_blank"}, disp_blank, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset.
    #35;
    chk("por.score_tens", score_tens, 8'd0);
    chk("por.best_ones",  best_ones,  8'd0);
    chk("por.disp_blank", disp_blank, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores round_won/game_over; first edge after release is live.
    step(0, 1, 0, 0, "idle_rw");
    step(0, 0, 1, 0, "idle_go");
    step(0, 0, 0, 1, "idle_tick");

    // Twelve rounds, crossing 09 -> 10.
    step(1, 0, 0, 0, "start1");
    for (int i = 0; i < 12; i++) step(0, 1, 0, 1, "count12");
    chk("twelve.tens", score_tens, 8'd1);
    chk("twelve.ones", score_ones, 8'd2);

    // Restart within PLAY, then score 7 and finish with a record.
    step(1, 0, 0, 0, "restart_play");
    chk("restart.ones", score_ones, 8'd0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, "count7");
    step(0, 0, 1, 0, "over7");
    for (int i = 0; i < 30; i++) step(0, (i == 3), (i == 5), 1, "blink7");
    step(0, 0, 0, 0, "hold7");
    do_reset("midblink_rst");
    step(0, 1, 0, 0, "post_rst_idle");

    // Game 1 scores 5, game 2 scores 3: best stays 05, no record, no blink.
    step(1, 0, 0, 0, "g1_start");
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, "g1_count");
    step(0, 0, 1, 0, "g1_over");
    step(1, 0, 0, 0, "g2_start");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "g2_count");
    step(0, 0, 1, 0, "g2_over");
    for (int i = 0; i < 30; i++) step(0, 0, 0, 1, "g2_ticks");
    chk("g2.best_ones", best_ones, BestEn ? 8'd5 : 8'd0);
    chk("g2.new_record", new_record, 8'd0);
    chk("g2.disp_blank", disp_blank, 8'd0);

    // game_over and round_won together: no increment, pre-event score becomes best.
    do_reset("rst2");
    step(1, 0, 0, 0, "g3_start");
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, "g3_count");
    step(0, 1, 1, 0, "g3_over_rw");
    chk("g3.score_ones", score_ones, 8'd4);
    chk("g3.best_ones", best_ones, BestEn ? 8'd4 : 8'd0);
    step(1, 1, 1, 1, "all_pulses_over");
    step(0, 1, 0, 0, "one");
    step(1, 0, 1, 0, "start_beats_over");

    // Saturation at 99, record, full blink cycle, restart clears blink.
    for (int i = 0; i < 100; i++) step(0, 1, 0, 0, "count100");
    chk("sat.tens", score_tens, 8'd9);
    chk("sat.ones", score_ones, 8'd9);
    step(0, 0, 1, 0, "over99");
    chk("over99.new_record", new_record, BestEn ? 8'd1 : 8'd0);
    for (int i = 0; i < 25; i++) step(0, 0, 0, 1, "blink_on");
    chk("blink_on", disp_blank, BestEn ? 8'd1 : 8'd0);
    for (int i = 0; i < 25; i++) step(0, 0, 0, 1, "blink_off");
    chk("blink_off", disp_blank, 8'd0);
    for (int i = 0; i < 25; i++) step(0, 0, 0, 1, "blink_on2");
    step(1, 0, 0, 1, "restart_blink");
    chk("restart.disp_blank", disp_blank, 8'd0);
    chk("restart.score_tens", score_tens, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
